// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the keypad lock controller.
//   state_t    - controller FSM states
//   key_in_t   - bundled keypad/command inputs sampled each cycle
//   max2()     - helper used to size the dwell timer
package lock_pkg;

    localparam int CODE_W     = 16;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        ENTRY,
        VERIFY,
        OPEN,
        LOCKOUT,
        PROG
    } state_t;

    typedef struct packed {
        logic               key_valid;
        logic [DIGIT_W-1:0] key_val;
        logic               enter;
        logic               clear;
        logic               prog_req;
    } key_in_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_code_cmp.sv
// lock_code_cmp: equality compare of the entry buffer against the stored code.
//   a, b : CODE_W-bit operands
//   eq   : 1 when a == b
module lock_code_cmp
    import lock_pkg::*;
(
    input  logic [CODE_W-1:0] a,
    input  logic [CODE_W-1:0] b,
    output logic              eq
);

    assign eq = (a == b);

endmodule

// File: rtl/lock_ctrl.sv
// lock_ctrl: keypad code lock with retry lockout and timed unlock.
//   clk, rst          : clock, synchronous active-high reset
//   key_valid/key_val : digit strobe and 4-bit digit
//   enter, clear      : submit entry / discard entry (relocks when open)
//   prog_req          : request code change while open
//   unlocked, alarm   : high in OPEN / LOCKOUT
//   prog_mode         : high in PROG
//   digit_cnt         : digits held in the entry buffer (0..4)
//   fail_cnt          : consecutive failed entries
// Build option: define LOCK_PROG_EN to enable the code-programming mode;
// without it the stored code is the constant DEFAULT_CODE.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int                MAX_TRIES      = 3,
    parameter int                UNLOCK_CYCLES  = 500,
    parameter int                LOCKOUT_CYCLES = 1000,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = 16'h1234
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_val,
    input  logic               enter,
    input  logic               clear,
    input  logic               prog_req,
    output logic               unlocked,
    output logic               alarm,
    output logic               prog_mode,
    output logic [CNT_W-1:0]   digit_cnt,
    output logic [CNT_W-1:0]   fail_cnt
);

    localparam int             TMAX   = max2(UNLOCK_CYCLES, LOCKOUT_CYCLES);
    localparam int             TW     = $clog2(TMAX + 1);
    localparam logic [TW-1:0]  U_LAST = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]  L_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0]  T_SAT  = TW'(TMAX);

    key_in_t             kin;
    state_t              state, state_n;
    logic [CODE_W-1:0]   entry_buf, buf_n;
    logic [CODE_W-1:0]   code;
    logic [CNT_W-1:0]    cnt_n, fail_n, fail_inc;
    logic [TW-1:0]       timer, timer_n;
    logic                code_eq;
    logic                buf_full;

    assign kin      = {key_valid, key_val, enter, clear, prog_req};
    assign buf_full = (digit_cnt == CNT_W'(NUM_DIGITS));
    assign fail_inc = fail_cnt + CNT_W'(1);

    lock_code_cmp u_cmp (
        .a  (entry_buf),
        .b  (code),
        .eq (code_eq)
    );

`ifdef LOCK_PROG_EN
    logic [CODE_W-1:0] code_n;
    logic              prog_ok;
    assign prog_ok = kin.prog_req;
`else
    logic              prog_ok;
    logic              prog_unused;
    assign prog_ok     = 1'b0;
    assign prog_unused = kin.prog_req;
    assign code        = DEFAULT_CODE;
    assign prog_mode   = 1'b0;
`endif

    always_comb begin
        state_n = state;
        buf_n   = entry_buf;
        cnt_n   = digit_cnt;
        fail_n  = fail_cnt;
`ifdef LOCK_PROG_EN
        code_n  = code;
`endif
        case (state)
            ENTRY: begin
                if (kin.clear) begin
                    buf_n = '0;
                    cnt_n = '0;
                end else if (kin.enter) begin
                    state_n = VERIFY;
                end else if (kin.key_valid && !buf_full) begin
                    buf_n = {entry_buf[CODE_W-DIGIT_W-1:0], kin.key_val};
                    cnt_n = digit_cnt + CNT_W'(1);
                end
            end
            VERIFY: begin
                // a short entry never matches, even if its value happens to
                buf_n = '0;
                cnt_n = '0;
                if (code_eq && buf_full) begin
                    state_n = OPEN;
                    fail_n  = '0;
                end else begin
                    fail_n  = fail_inc;
                    state_n = (fail_inc == CNT_W'(MAX_TRIES)) ? LOCKOUT : ENTRY;
                end
            end
            OPEN: begin
                if (kin.clear) begin
                    state_n = ENTRY;
                end else if (prog_ok) begin
                    state_n = PROG;
                    buf_n   = '0;
                    cnt_n   = '0;
                end else if (timer == U_LAST) begin
                    state_n = ENTRY;
                end
            end
            LOCKOUT: begin
                if (timer == L_LAST) begin
                    state_n = ENTRY;
                    fail_n  = '0;
                end
            end
            PROG: begin
                if (kin.clear) begin
                    state_n = ENTRY;
                    buf_n   = '0;
                    cnt_n   = '0;
                end else if (kin.enter) begin
`ifdef LOCK_PROG_EN
                    if (buf_full) code_n = entry_buf;
`endif
                    state_n = ENTRY;
                    buf_n   = '0;
                    cnt_n   = '0;
                end else if (kin.key_valid && !buf_full) begin
                    buf_n = {entry_buf[CODE_W-DIGIT_W-1:0], kin.key_val};
                    cnt_n = digit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ENTRY;
                buf_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // dwell timer restarts on every state change and saturates instead of wrapping
    always_comb begin
        timer_n = timer;
        if (state_n != state)  timer_n = '0;
        else if (timer != T_SAT) timer_n = timer + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ENTRY;
            entry_buf <= '0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            timer     <= '0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_n;
            entry_buf <= buf_n;
            digit_cnt <= cnt_n;
            fail_cnt  <= fail_n;
            timer     <= timer_n;
            unlocked  <= (state_n == OPEN);
            alarm     <= (state_n == LOCKOUT);
        end
    end

`ifdef LOCK_PROG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            code      <= DEFAULT_CODE;
            prog_mode <= 1'b0;
        end else begin
            code      <= code_n;
            prog_mode <= (state_n == PROG);
        end
    end
`endif

endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: directed and randomized stimulus against a countdown-based
// reference model; expected outputs are queued per cycle and checked by a
// separate monitor on the falling edge.
module tb_lock_ctrl;

    localparam int          MT = 3;
    localparam int          UC = 8;
    localparam int          LC = 16;
    localparam logic [15:0] DC = 16'h1234;
`ifdef LOCK_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, key_valid = 1'b0, enter = 1'b0, clear = 1'b0, prog_req = 1'b0;
    logic [3:0] key_val = 4'd0;
    logic       unlocked, alarm, prog_mode;
    logic [2:0] digit_cnt, fail_cnt;

    always #5 clk = ~clk;

    lock_ctrl #(
        .MAX_TRIES      (MT),
        .UNLOCK_CYCLES  (UC),
        .LOCKOUT_CYCLES (LC),
        .DEFAULT_CODE   (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_val   (key_val),
        .enter     (enter),
        .clear     (clear),
        .prog_req  (prog_req),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .prog_mode (prog_mode),
        .digit_cnt (digit_cnt),
        .fail_cnt  (fail_cnt)
    );

    typedef struct {
        logic       unl, alm, pm;
        logic [2:0] dc, fc;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, ncyc = 0;

    // reference model: entry as a digit queue, open/lockout as remaining-cycle counts
    int m_digits[$];
    int m_code, m_fails, m_open, m_lock;
    bit m_prog, m_verify;

    function automatic int digits_val();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit kv, input int kval,
                              input bit en, input bit clr, input bit pr);
        if (r) begin
            m_digits.delete();
            m_code = DC; m_fails = 0; m_open = 0; m_lock = 0; m_prog = 0; m_verify = 0;
        end else if (m_verify) begin
            m_verify = 0;
            if (m_digits.size() == 4 && digits_val() == m_code) begin
                m_open = UC; m_fails = 0;
            end else begin
                m_fails++;
                if (m_fails == MT) m_lock = LC;
            end
            m_digits.delete();
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
        end else if (m_open > 0) begin
            if (clr) m_open = 0;
            else if (PROG_EN && pr) begin m_open = 0; m_prog = 1; m_digits.delete(); end
            else m_open--;
        end else if (m_prog) begin
            if (clr) begin m_prog = 0; m_digits.delete(); end
            else if (en) begin
                if (m_digits.size() == 4) m_code = digits_val();
                m_prog = 0; m_digits.delete();
            end else if (kv && m_digits.size() < 4) m_digits.push_back(kval);
        end else begin
            if (clr) m_digits.delete();
            else if (en) m_verify = 1;
            else if (kv && m_digits.size() < 4) m_digits.push_back(kval);
        end
    endtask

    task automatic cyc(input bit r, input bit kv, input logic [3:0] kval,
                       input bit en, input bit clr, input bit pr);
        exp_t e;
        rst = r; key_valid = kv; key_val = kval; enter = en; clear = clr; prog_req = pr;
        model_step(r, kv, int'(kval), en, clr, pr);
        e.unl = (m_open > 0);
        e.alm = (m_lock > 0);
        e.pm  = m_prog;
        e.dc  = 3'(m_digits.size());
        e.fc  = 3'(m_fails);
        e.cyc = ncyc++;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 0, 0, 0);
    endtask

    task automatic key(input logic [3:0] d);
        cyc(0, 1, d, 0, 0, 0);
    endtask

    task automatic try_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) key(c[15-4*i -: 4]);
        cyc(0, 0, 4'd0, 1, 0, 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({unlocked, alarm, prog_mode, digit_cnt, fail_cnt} !==
                {e.unl, e.alm, e.pm, e.dc, e.fc}) begin
                fails++;
                $display("FAIL cycle%0d: got unl=%b alm=%b pm=%b dc=%0d fc=%0d, want unl=%b alm=%b pm=%b dc=%0d fc=%0d",
                         e.cyc, unlocked, alarm, prog_mode, digit_cnt, fail_cnt,
                         e.unl, e.alm, e.pm, e.dc, e.fc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kind, nd, nr;
        logic [15:0] c;

        cyc(1, 0, 4'd0, 0, 0, 0);
        idle(2);

        // correct code, full open window
        try_code(16'h1234); idle(12);
        // clear while open
        try_code(16'h1234); idle(3); cyc(0, 0, 4'd0, 0, 1, 0); idle(3);
        // three failures into lockout; correct code ignored during lockout
        for (int i = 0; i < 3; i++) begin try_code(16'h9999); idle(2); end
        try_code(16'h1234); idle(20);
        // short entry fails, long entry drops the 5th digit
        key(4'd1); key(4'd2); key(4'd3); cyc(0, 0, 4'd0, 1, 0, 0); idle(2);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); cyc(0, 0, 4'd0, 1, 0, 0); idle(10);
        // reprogramming, then reset restores the default code
        try_code(16'h1234); idle(2); cyc(0, 0, 4'd0, 0, 0, 1);
        try_code(16'h5678); idle(2);
        try_code(16'h1234); idle(3);
        try_code(16'h5678); idle(10);
        cyc(1, 0, 4'd0, 0, 0, 0);
        try_code(16'h1234); idle(10);
        // key and enter together with a full buffer; clear and enter together
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); cyc(0, 1, 4'd5, 1, 0, 0); idle(3);
        cyc(1, 0, 4'd0, 0, 0, 0); idle(2);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); cyc(0, 1, 4'd7, 1, 1, 0); idle(3);

        // randomized attempts with random side traffic
        for (int a = 0; a < 150; a++) begin
            kind = int'($urandom_range(0, 9));
            c    = (kind < 5) ? 16'(m_code) : 16'($urandom);
            nd   = int'($urandom_range(3, 5));
            for (int i = 0; i < nd; i++) begin
                if (i < 4) key(c[15-4*i -: 4]);
                else       key(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 2) == 0) idle(1);
            end
            cyc(0, 0, 4'd0, 1, 0, 0);
            idle(int'($urandom_range(1, 3)));
            nr = int'($urandom_range(2, 12));
            for (int j = 0; j < nr; j++)
                cyc($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
            if (kind == 9) idle(int'($urandom_range(0, 20)));
        end

        repeat (4) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_TRIES, default 3, meaning consecutive failed entries before lockout (1..7).
REQ-002 The block SHALL have parameter UNLOCK_CYCLES, default 500, meaning clock cycles the lock stays open.
REQ-003 The block SHALL have parameter LOCKOUT_CYCLES, default 1000, meaning clock cycles of lockout after MAX_TRIES failures.
REQ-004 The block SHALL have parameter DEFAULT_CODE, default 16'h1234, meaning the stored code after reset (four 4-bit digits).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port key_valid, input, 1 bit: single-cycle digit strobe.
REQ-008 The block SHALL have port key_val, input, 4 bits: digit value, sampled when key_valid=1.
REQ-009 The block SHALL have port enter, input, 1 bit: submit strobe.
REQ-010 The block SHALL have port clear, input, 1 bit: discard entry buffer; relock when open.
REQ-011 The block SHALL have port prog_req, input, 1 bit: request code change while open.
REQ-012 The block SHALL have port unlocked, output, 1 bit: high in OPEN.
REQ-013 The block SHALL have port alarm, output, 1 bit: high in LOCKOUT.
REQ-014 The block SHALL have port prog_mode, output, 1 bit: high in PROG.
REQ-015 The block SHALL have port digit_cnt, output, 3 bits: digits held in the entry buffer (0..4).
REQ-016 The block SHALL have port fail_cnt, output, 3 bits: consecutive failures.

Function
REQ-017 The FSM SHALL have states ENTRY, VERIFY, OPEN, LOCKOUT, PROG; the state and all outputs SHALL be registered.
REQ-018 In ENTRY or PROG, key_valid with digit_cnt<4 SHALL shift the buffer (buf <= {buf[11:0],key_val}) and increment digit_cnt; with digit_cnt==4 the digit SHALL be ignored.
REQ-019 Input priority SHALL be clear > enter > key_valid when asserted in the same cycle.
REQ-020 enter in ENTRY SHALL move to VERIFY next cycle; VERIFY SHALL register the equality of buf against the stored code and digit_cnt==4, and SHALL exit after exactly one cycle, so unlocked rises 2 cycles after enter.
REQ-021 On VERIFY match: OPEN, fail_cnt<=0. On mismatch: fail_cnt+1; go to LOCKOUT if the new value equals MAX_TRIES, else go to ENTRY. Both paths clear buf and digit_cnt.
REQ-022 OPEN SHALL last UNLOCK_CYCLES cycles then return to ENTRY; clear in OPEN SHALL return to ENTRY on the next cycle.
REQ-023 LOCKOUT SHALL ignore key_valid, enter, clear and prog_req; after LOCKOUT_CYCLES cycles it SHALL go to ENTRY with fail_cnt<=0.
REQ-024 Inputs in VERIFY SHALL be ignored.
REQ-025 The dwell timer SHALL be sized $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1) bits, load 0 on state entry, and never wrap.

Reset
REQ-026 rst SHALL force ENTRY, buf=0, digit_cnt=0, fail_cnt=0, timer=0, unlocked=0, alarm=0, prog_mode=0, stored code=DEFAULT_CODE.
REQ-027 rst asserted in any state (including OPEN, LOCKOUT or mid-entry) SHALL take effect on the next edge and override all other inputs.

Configuration
REQ-028 With LOCK_PROG_EN defined, prog_req in OPEN SHALL enter PROG with buf cleared; in PROG, enter with digit_cnt==4 SHALL write buf to the stored code, enter with digit_cnt<4 SHALL leave the code unchanged, clear SHALL abort; all three exits SHALL go to ENTRY.
REQ-029 Without LOCK_PROG_EN, prog_req SHALL be ignored, PROG SHALL be unreachable, prog_mode SHALL be tied 0, and the stored code SHALL be the constant DEFAULT_CODE.

Structure
REQ-030 Package lock_pkg SHALL hold the state enum, CODE_W=16, DIGIT_W=4 and NUM_DIGITS=4.
REQ-031 The 16-bit compare SHALL be a sub-module lock_code_cmp (inputs a and b, output eq), instanced once.

Verification
REQ-032 Keys 1,2,3,4 then enter -> unlocked=1 exactly 2 cycles after enter and fail_cnt=0.
REQ-033 With UNLOCK_CYCLES=8: after unlock -> unlocked falls after 8 cycles; a repeated run with clear at cycle 3 -> unlocked falls next cycle.
REQ-034 With MAX_TRIES=3 and LOCKOUT_CYCLES=16: three entries of 9,9,9,9 -> fail_cnt goes 1, 2, then alarm=1; the correct code during lockout is ignored; after 16 cycles alarm=0 and fail_cnt=0.
REQ-035 Keys 1,2,3 then enter -> failure (fail_cnt=1); keys 1,2,3,4,5 then enter -> unlock (5th digit dropped).
REQ-036 With LOCK_PROG_EN: unlock, prog_req, keys 5,6,7,8, enter -> 1234 now fails and 5678 unlocks; rst -> 1234 unlocks again.
REQ-037 key_valid and enter in the same cycle with 4 digits -> the digit is ignored and verify proceeds; rst during OPEN -> unlocked=0 next cycle.
